regfile_param: RTL and testbench

- Parametrised multi-read-port register file; the next generation of the fixed 64-bit enable register and 32x64 register file.
- Storage is NUM_REGS x DATA_W, built from enable-gated registers.
- Read ports are combinational; there is one synchronous write port.
- The highest-index register is hardwired to zero (ARM XZR).
- Serves the single-cycle CPU now and the pipelined CPU next, via optional write-to-read bypass.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_param_reg_en.sv | 26 ++
 rtl/regfile_param.sv | 81 ++++++++
 tb/tb_regfile_param.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised register file.
// Optional write-to-read bypass is enabled in regfile_param by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  typedef logic [ADDR_W_DEF-1:0] rf_addr_t;

  // Index of the hardwired-zero register (ARM XZR) for a given address width.
  function automatic int zero_idx(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/regfile_param_reg_en.sv
// DATA_W-wide storage register with synchronous active-high reset and load enable.
module reg_en_param #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    data_d = en ? d : data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: NUM_RD combinational read ports, one synchronous write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int NUM_RD      = NUM_RD_DEF,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_en,
  input  logic [ADDR_W-1:0]          write_addr,
  input  logic [DATA_W-1:0]          DataIn,
  input  logic [NUM_RD*ADDR_W-1:0]   read_addr,
  output logic [NUM_RD*DATA_W-1:0]   DataOut,
  output logic [(2**ADDR_W)-1:0]     written
);

  localparam int                NUM_REGS  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(zero_idx(ADDR_W));
  localparam bit                ZERO_ON   = (ZERO_REG_EN != 0);

  logic [NUM_REGS-1:0] wr_onehot;
  logic [NUM_REGS-1:0] written_d;
  logic [NUM_REGS-1:0] written_q;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;

  always_comb begin
    wr_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_onehot[i] = write_en && (write_addr == ADDR_W'(i));
    end
    if (ZERO_ON) wr_onehot[NUM_REGS-1] = 1'b0;
  end

  always_comb begin
    written_d = written_q | wr_onehot;
  end

  always_ff @(posedge clk) begin
    if (reset) written_q <= '0;
    else       written_q <= written_d;
  end

  assign written = written_q;

  // The zero register has no storage at all when enabled.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (ZERO_ON && (i == NUM_REGS-1)) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_ff
      reg_en_param #(.DATA_W(DATA_W)) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (wr_onehot[i]),
        .d     (DataIn),
        .q     (regs[i])
      );
    end
  end

  always_comb begin
    DataOut = '0;
    rd_addr = '0;
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr = read_addr[k*ADDR_W +: ADDR_W];
      rd_data = regs[rd_addr];
`ifdef REGFILE_BYPASS_EN
      if (write_en && !reset && (rd_addr == write_addr)) rd_data = DataIn;
`endif
      if (ZERO_ON && (rd_addr == ZERO_ADDR)) rd_data = '0;
      DataOut[k*DATA_W +: DATA_W] = rd_data;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default 2-port/64-bit build plus a 4-port/32-bit build.
module tb_regfile_param;
  import regfile_pkg::*;

  localparam int DW = 64, AW = 5, NR = 2, NREG = 32;
  localparam int DW2 = 32, NR2 = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] DataIn;
  logic [NR*AW-1:0] read_addr;
  logic [NR*DW-1:0] DataOut;
  logic [NREG-1:0] written;

  logic reset2, write_en2;
  logic [AW-1:0] write_addr2;
  logic [DW2-1:0] data_in2;
  logic [NR2*AW-1:0] read_addr2;
  logic [NR2*DW2-1:0] data_out2;
  logic [NREG-1:0] written2;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_v, got_v;
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .DataIn(DataIn), .read_addr(read_addr), .DataOut(DataOut), .written(written)
  );

  regfile_param #(.DATA_W(DW2), .ADDR_W(AW), .NUM_RD(NR2), .ZERO_REG_EN(1)) dut_wide (
    .clk(clk), .reset(reset2), .write_en(write_en2), .write_addr(write_addr2),
    .DataIn(data_in2), .read_addr(read_addr2), .DataOut(data_out2), .written(written2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; write_en = 1'b0; write_addr = '0; DataIn = '0; read_addr = '0;
    tick();
    reset = 1'b0;
    for (int a = 0; a < NREG; a++) begin
      read_addr = {AW'(a), AW'(a)};
      exp_q.push_back('0);
      exp_q.push_back('0);
      #1;
      for (int k = 0; k < NR; k++) begin
        exp_v = exp_q.pop_front();
        got_v = DataOut[k*DW +: DW];
        n_cmp++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL reset_read addr=%0d port=%0d got=%h exp=%h", a, k, got_v, exp_v);
        end
      end
    end
    n_cmp++;
    if (written !== '0) begin
      n_fail++;
      $display("FAIL reset_written got=%h exp=0", written);
    end
  endtask

  task automatic test_write();
    rf_addr_t a0;
    write_en = 1'b1; write_addr = 5'd3; DataIn = 64'd1348;
    tick();
    write_addr = 5'd7; DataIn = 64'd45948;
    tick();
    write_en = 1'b0;
    a0 = 5'd3;
    read_addr = {5'd7, a0};
    exp_q.push_back(64'd1348);   // port 0 reads addr 3
    exp_q.push_back(64'd45948);  // port 1 reads addr 7
    #1;
    for (int k = 0; k < NR; k++) begin
      exp_v = exp_q.pop_front();
      got_v = DataOut[k*DW +: DW];
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL write_read port=%0d got=%0d exp=%0d", k, got_v, exp_v);
      end
    end
    n_cmp++;
    if (written !== 32'h0000_0088) begin
      n_fail++;
      $display("FAIL write_written got=%h exp=00000088", written);
    end
  endtask

  task automatic test_hold();
    write_en = 1'b0; write_addr = 5'd3; DataIn = 64'hDEAD;
    repeat (3) tick();
    read_addr = {5'd3, 5'd3};
    exp_q.push_back(64'd1348);
    exp_q.push_back(64'd1348);
    #1;
    for (int k = 0; k < NR; k++) begin
      exp_v = exp_q.pop_front();
      got_v = DataOut[k*DW +: DW];
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL hold_read port=%0d got=%0d exp=%0d", k, got_v, exp_v);
      end
    end
    n_cmp++;
    if (written !== 32'h0000_0088) begin
      n_fail++;
      $display("FAIL hold_written got=%h exp=00000088", written);
    end
  endtask

  task automatic test_zero_reg();
    write_en = 1'b1; write_addr = 5'd31; DataIn = 64'hFFFF;
    read_addr = {5'd31, 5'd31};
    exp_q.push_back('0);
    exp_q.push_back('0);
    #1;
    for (int k = 0; k < NR; k++) begin
      exp_v = exp_q.pop_front();
      got_v = DataOut[k*DW +: DW];
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL zero_same_cycle port=%0d got=%h exp=%h", k, got_v, exp_v);
      end
    end
    tick();
    write_en = 1'b0;
    read_addr = {5'd3, 5'd31};
    exp_q.push_back('0);
    exp_q.push_back(64'd1348);
    #1;
    for (int k = 0; k < NR; k++) begin
      exp_v = exp_q.pop_front();
      got_v = DataOut[k*DW +: DW];
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL zero_after port=%0d got=%h exp=%h", k, got_v, exp_v);
      end
    end
    n_cmp++;
    if (written[31] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_written got=%b exp=0", written[31]);
    end
  endtask

  task automatic test_read_during_write();
    write_en = 1'b1; write_addr = 5'd5; DataIn = 64'd77;
    read_addr = {5'd3, 5'd5};
    exp_q.push_back(BYP ? 64'd77 : 64'd0);
    exp_q.push_back(64'd1348);
    #1;
    for (int k = 0; k < NR; k++) begin
      exp_v = exp_q.pop_front();
      got_v = DataOut[k*DW +: DW];
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL rdw_same_cycle port=%0d got=%0d exp=%0d", k, got_v, exp_v);
      end
    end
    tick();
    write_en = 1'b0;
    exp_q.push_back(64'd77);
    #1;
    exp_v = exp_q.pop_front();
    got_v = DataOut[0 +: DW];
    n_cmp++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL rdw_next_cycle got=%0d exp=%0d", got_v, exp_v);
    end
  endtask

  task automatic test_reset_priority();
    // Reset raised mid-cycle must not disturb contents before the edge, nor bypass.
    #2;
    reset = 1'b1; write_en = 1'b1; write_addr = 5'd3; DataIn = 64'd9;
    read_addr = {5'd7, 5'd3};
    exp_q.push_back(64'd1348);
    exp_q.push_back(64'd45948);
    #1;
    for (int k = 0; k < NR; k++) begin
      exp_v = exp_q.pop_front();
      got_v = DataOut[k*DW +: DW];
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_midcycle port=%0d got=%0d exp=%0d", k, got_v, exp_v);
      end
    end
    tick();
    reset = 1'b0; write_en = 1'b0;
    for (int a = 0; a < NREG; a += 2) begin
      read_addr = {AW'(a + 1), AW'(a)};
      exp_q.push_back('0);
      exp_q.push_back('0);
      #1;
      for (int k = 0; k < NR; k++) begin
        exp_v = exp_q.pop_front();
        got_v = DataOut[k*DW +: DW];
        n_cmp++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL reset_priority addr=%0d got=%h exp=%h", a + k, got_v, exp_v);
        end
      end
    end
    n_cmp++;
    if (written !== '0) begin
      n_fail++;
      $display("FAIL reset_priority_written got=%h exp=0", written);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] mdl [NREG];
    logic [NREG-1:0] wmask;
    logic we;
    logic [AW-1:0] wa, ra0, ra1;
    logic [DW-1:0] wd;
    for (int i = 0; i < NREG; i++) mdl[i] = '0;
    wmask = '0;
    for (int it = 0; it < 150; it++) begin
      we = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, NREG - 1));
      wd = {$urandom, $urandom};
      ra0 = AW'($urandom_range(0, NREG - 1));
      ra1 = (it % 4 == 0) ? wa : AW'($urandom_range(0, NREG - 1));
      write_en = we; write_addr = wa; DataIn = wd; read_addr = {ra1, ra0};
      for (int k = 0; k < NR; k++) begin
        logic [AW-1:0] ra;
        ra = (k == 0) ? ra0 : ra1;
        if (ra == 5'd31)               exp_q.push_back('0);
        else if (BYP && we && ra == wa) exp_q.push_back(wd);
        else                           exp_q.push_back(mdl[ra]);
      end
      #1;
      for (int k = 0; k < NR; k++) begin
        exp_v = exp_q.pop_front();
        got_v = DataOut[k*DW +: DW];
        n_cmp++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL random_read it=%0d port=%0d got=%h exp=%h", it, k, got_v, exp_v);
        end
      end
      tick();
      if (we && wa != 5'd31) begin
        mdl[wa] = wd;
        wmask[wa] = 1'b1;
      end
      n_cmp++;
      if (written !== wmask) begin
        n_fail++;
        $display("FAIL random_written it=%0d got=%h exp=%h", it, written, wmask);
      end
    end
    write_en = 1'b0;
  endtask

  task automatic test_wide_ports();
    reset2 = 1'b1; write_en2 = 1'b0; write_addr2 = '0; data_in2 = '0; read_addr2 = '0;
    tick();
    reset2 = 1'b0;
    write_en2 = 1'b1; write_addr2 = 5'd3; data_in2 = 32'd1348;
    tick();
    write_addr2 = 5'd7; data_in2 = 32'd45948;
    tick();
    write_en2 = 1'b0;
    read_addr2 = {5'd7, 5'd0, 5'd3, 5'd7};
    exp_q.push_back(64'd45948);
    exp_q.push_back(64'd1348);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd45948);
    #1;
    for (int k = 0; k < NR2; k++) begin
      exp_v = exp_q.pop_front();
      got_v = {32'd0, data_out2[k*DW2 +: DW2]};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL wide_read port=%0d got=%0d exp=%0d", k, got_v, exp_v);
      end
    end
    n_cmp++;
    if (written2 !== 32'h0000_0088) begin
      n_fail++;
      $display("FAIL wide_written got=%h exp=00000088", written2);
    end
  endtask

  initial begin
    reset = 1'b0; write_en = 1'b0; write_addr = '0; DataIn = '0; read_addr = '0;
    reset2 = 1'b0; write_en2 = 1'b0; write_addr2 = '0; data_in2 = '0; read_addr2 = '0;
    #2;
    test_reset();
    test_write();
    test_hold();
    test_zero_reg();
    test_read_during_write();
    test_reset_priority();
    test_random();
    test_wide_ports();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
